prng_arbiter: RTL
=================

# prng_arbiter

Shares one 16-bit LFSR random-word source among `NREQ` requesters through a round-robin arbiter, and sequences the generator between grants so that no two consumers receive overlapping bit streams. It also handles reseeding. The block sits between the LFSR datapath and the consumers (test-pattern, noise and nonce clients): it advances the register a fixed number of steps per word, holds the finished word, and hands it to exactly one requester per grant.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `STEPS`, 16, LFSR shifts between successive delivered words (1..255)
- `DEFAULT_SEED`, 16'hACE1, seed used at reset and in place of any zero seed
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `seed_valid`  in  1  reseed request
- `seed`  in  16  new seed, sampled when `seed_valid & seed_ready`
- `seed_ready`  out  1  seed can be accepted this cycle
- `req`  in  NREQ  per-requester word request, level, held until granted
- `gnt`  out  NREQ  one-hot grant, one-cycle pulse
- `rnd_valid`  out  1  high exactly in grant cycles
- `rnd_data`  out  16  granted word; holds last value between grants
- `word_ready`  out  1  finished word is waiting (state READY)

## Operation
- LFSR step: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}` (x^16+x^14+x^13+x^11+1, maximal length). The register advances only in FILL.
- Zero is never loaded: a `seed` of 0 loads `DEFAULT_SEED`.
- States:
  - FILL: shift each cycle and increment `step_cnt` (8 bits). After the STEPS-th shift, go to READY with `step_cnt` cleared.
  - READY: the LFSR is frozen and holds the word. If `seed_valid`, load the seed and go to FILL. Otherwise, if `|req`, go to GRANT. Otherwise stay.
  - GRANT: for one cycle, `gnt` is one-hot to the winner, `rnd_valid`=1 and `rnd_data` equals the frozen LFSR value. Then go to FILL.
- Round robin:
  - Pointer `ptr` starts at 0.
  - The winner is the first requester with `req` set, searching `ptr`, `ptr+1`, … modulo NREQ.
  - On a grant, `ptr` becomes winner+1, wrapping at NREQ.
  - `ptr` does not change without a grant.
- Requests are sampled only in READY. A requester may drop `req` before being granted; dropped requests are ignored.
- Seeding:
  - `seed_ready` = 1 in FILL and READY, 0 in GRANT.
  - An accepted seed in FILL or READY loads the LFSR on that edge, clears `step_cnt` and enters FILL. Partial progress is discarded.
  - `ptr` is unaffected by seeding.
- A seed and a request arriving together in READY: the seed wins, no grant is issued that cycle, and the request remains pending.

## Timing
- Reset (async assert, takes effect immediately):
  - Outputs: `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `word_ready`=0, `seed_ready`=1.
  - Internal: `lfsr`=DEFAULT_SEED, state FILL, `step_cnt`=0, `ptr`=0.
- Deassertion is synchronized by the system. The first edge after release performs shift 1.
- Entering FILL at edge e puts the block in READY after edge e+STEPS, so `word_ready`=1 from that point.
- `req` seen in READY at edge k gives `gnt`/`rnd_valid` high for the cycle after edge k.
- Service interval with continuous requests: STEPS+2 cycles per word (STEPS FILL cycles, 1 READY, 1 GRANT).
- Reset asserted mid-FILL or mid-GRANT aborts the operation immediately. No grant pulse survives, and no partial word is delivered.
- All outputs are registered or decoded from state only. There are no combinational paths from `req`/`seed_valid` to `gnt`/`rnd_valid`/`seed_ready`.

## Test plan
- Reset, STEPS=1, `req`=4'b0001 held → first grant is `gnt`=0001 with `rnd_data`=16'h59C3; the second grant has `rnd_data`=16'hB387, 3 cycles later.
- STEPS=1, `req`=4'b1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, one every 3 cycles, with each `rnd_valid` pulse exactly 1 cycle.
- STEPS=1, seed 16'h0001 accepted in READY, then `req[2]` → `gnt`=0100 with `rnd_data`=16'h0002. Separately, seed 16'h0000 gives first word 16'h59C3.
- STEPS=16, `seed_valid` and `req[1]` asserted together in READY → no grant that cycle. The grant to requester 1 follows 16 FILL cycles later and equals the word after 16 shifts from the new seed (checked against a reference model).
- STEPS=16, `rst_n` pulled low at shift 7 → outputs go to 0 immediately. After release, `word_ready` rises after 16 shifts of 16'hACE1, and `ptr` restarts at 0.
- Requester 3 drops `req` during FILL before grant, with `req[0]` also high → grant goes to 0 only. Check one-hot `gnt`, that `rnd_data` holds between grants, and that the LFSR is never zero over 70000 words (STEPS=1).

Source files
------------

// File: rtl/prng_arbiter.sv
// prng_arbiter: one 16-bit Galois-free Fibonacci LFSR shared among NREQ
// consumers. The register is advanced STEPS times between delivered words,
// the finished word is frozen, and a round-robin arbiter hands it to exactly
// one requester per grant, so no two consumers ever see overlapping streams.
module prng_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          STEPS        = 16,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            seed_valid,
    input  logic [15:0]     seed,
    output logic            seed_ready,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [15:0]     rnd_data,
    output logic            word_ready
);

    localparam int         PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_READY = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_lfsr;
    logic [7:0]        r_step_cnt;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic [15:0]       r_rnd_data;

    logic              w_seed_acc;
    logic [15:0]       w_seed_val;
    logic              w_fill_done;
    logic              w_grant;
    logic [2*NREQ-1:0] w_req_dbl;
    logic [NREQ-1:0]   w_req_rot;
    logic [PW:0]       w_off;
    logic [PW:0]       w_sum;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_ptr_nxt;
    logic [NREQ-1:0]   w_gnt_vec;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // A seed is only refused while a grant is on the bus; zero would lock up the LFSR
    assign w_seed_acc  = seed_valid & (r_state != S_GRANT);
    assign w_seed_val  = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    assign w_fill_done = (r_step_cnt == LAST_STEP);
    // A seed in READY wins over requests; the request simply stays pending
    assign w_grant     = (r_state == S_READY) & ~w_seed_acc & (|req);

    // Rotate requests so the search always starts at bit 0 = requester ptr
    assign w_req_dbl = {req, req};
    assign w_req_rot = NREQ'(w_req_dbl >> r_ptr);

    // Priority encode the rotated vector: lowest set bit is the winner offset
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = (PW+1)'(i);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + w_off;
    assign w_win     = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
    assign w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
    assign w_gnt_vec = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: FILL -> READY -> GRANT -> FILL, seeds restart FILL
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_seed_acc)       w_state_nxt = S_FILL;
                else if (w_fill_done) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (w_seed_acc)       w_state_nxt = S_FILL;
                else if (|req)        w_state_nxt = S_GRANT;
            end
            S_GRANT: w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Status outputs decoded purely from state
    always_comb begin
        seed_ready = 1'b1;
        word_ready = 1'b0;
        rnd_valid  = 1'b0;
        case (r_state)
            S_READY: word_ready = 1'b1;
            S_GRANT: begin
                seed_ready = 1'b0;
                rnd_valid  = 1'b1;
            end
            default: ;
        endcase
    end

    // LFSR and step counter: advance only in FILL, reload on an accepted seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= DEFAULT_SEED;
            r_step_cnt <= '0;
        end else if (w_seed_acc) begin
            r_lfsr     <= w_seed_val;
            r_step_cnt <= '0;
        end else if (r_state == S_FILL) begin
            r_lfsr     <= lfsr_step(r_lfsr);
            r_step_cnt <= w_fill_done ? 8'd0 : r_step_cnt + 8'd1;
        end
    end

    // Grant pulse, round-robin pointer and delivered word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= '0;
            r_ptr      <= '0;
            r_rnd_data <= '0;
        end else begin
            r_gnt <= w_grant ? w_gnt_vec : '0;
            if (w_grant) begin
                r_ptr      <= w_ptr_nxt;
                r_rnd_data <= r_lfsr;
            end
        end
    end

    assign gnt      = r_gnt;
    assign rnd_data = r_rnd_data;

endmodule
